// File: rtl/pte_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pte_fetch_pkg
//  Purpose  : Shared types, defaults and helpers for the PTE fetch unit.
//  Revision : 1.0
// ============================================================================
package pte_fetch_pkg;

    localparam int LINE_BITS_DEFAULT   = 256;
    localparam int OFFSET_BITS_DEFAULT = $clog2(LINE_BITS_DEFAULT / 8);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    // Width of the 32-bit word index carved out of the line byte offset.
    function automatic int word_sel_width(input int offset_bits);
        return offset_bits - 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pte_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : pte_line_buffer
//  Purpose  : Single-line PTE buffer: valid/tag/data, fill, invalidate, lookup.
//  Revision : 1.0
// ============================================================================
module pte_line_buffer
    import pte_fetch_pkg::*;
#(
    parameter int LINE_BITS   = LINE_BITS_DEFAULT,
    parameter int ADDR_W      = 32,
    parameter int OFFSET_BITS = $clog2(LINE_BITS / 8)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_W-OFFSET_BITS-1:0] lookup_tag,
    input  logic [OFFSET_BITS-3:0]        word_sel,
    input  logic                          fill_en,
    input  logic                          fill_valid,
    input  logic [ADDR_W-OFFSET_BITS-1:0] fill_tag,
    input  logic [LINE_BITS-1:0]          fill_data,
    input  logic                          flush,
    input  logic                          snoop_write,
    input  logic [ADDR_W-OFFSET_BITS-1:0] snoop_tag,
    output logic                          hit,
    output logic                          snoop_match,
    output logic [31:0]                   word_out
);

    localparam int WORDS = 1 << word_sel_width(OFFSET_BITS);

    logic                          r_valid;
    logic [ADDR_W-OFFSET_BITS-1:0] r_tag;
    logic [LINE_BITS-1:0]          r_data;

    logic [31:0] w_buf_words  [WORDS];
    logic [31:0] w_fill_words [WORDS];

    for (genvar i = 0; i < WORDS; i++) begin : g_words
        assign w_buf_words[i]  = r_data[32*i +: 32];
        assign w_fill_words[i] = fill_data[32*i +: 32];
    end

    assign hit         = r_valid && (r_tag == lookup_tag);
    assign snoop_match = snoop_write && (snoop_tag == r_tag);
    // During a fill the requester wants the word straight from the incoming line.
    assign word_out    = fill_en ? w_fill_words[word_sel] : w_buf_words[word_sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else begin
            if (flush || snoop_match) begin
                r_valid <= 1'b0;
            end else if (fill_en) begin
                r_valid <= fill_valid;
            end
            if (fill_en) begin
                r_tag  <= fill_tag;
                r_data <= fill_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pte_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pte_fetch_unit
//  Purpose  : Page-table-walker memory responder with a one-line PTE buffer.
//  Revision : 1.0
// ============================================================================
module pte_fetch_unit
    import pte_fetch_pkg::*;
#(
    parameter int LINE_BITS   = LINE_BITS_DEFAULT,
    parameter int ADDR_W      = 32,
    parameter int OFFSET_BITS = $clog2(LINE_BITS / 8)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    pte_addr,
    input  logic                 mem_read,
    input  logic                 flush_tlb,
    input  logic [ADDR_W-1:0]    snoop_addr,
    input  logic                 snoop_write,
    output logic [31:0]          pte_in,
    output logic                 mem_resp,
    output logic                 access_fault,
    output logic [ADDR_W-1:0]    pmem_address,
    output logic                 pmem_read,
    input  logic [LINE_BITS-1:0] pmem_rdata,
    input  logic                 pmem_resp,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
);

    localparam int TAG_W = ADDR_W - OFFSET_BITS;
    localparam logic [31:0] C_SAT = 32'hFFFF_FFFF;

    state_t r_state, w_next;

    logic [31:0]       r_pte;
    logic              r_fault;
    logic              r_poison;
    logic [ADDR_W-1:0] r_paddr;
    logic [31:0]       r_hits;
    logic [31:0]       r_misses;

    logic [TAG_W-1:0]       w_req_tag;
    logic [TAG_W-1:0]       w_inflight_tag;
    logic [TAG_W-1:0]       w_snoop_tag;
    logic [OFFSET_BITS-3:0] w_sel;
    logic                   w_misaligned;
    logic                   w_fill;
    logic                   w_fill_valid;
    logic                   w_snoop_inflight;
    logic                   w_buf_hit;
    logic                   w_buf_snoop;
    logic                   w_hit;
    logic [31:0]            w_word;
    logic                   w_unused;

    assign w_req_tag        = pte_addr[ADDR_W-1:OFFSET_BITS];
    assign w_sel            = pte_addr[OFFSET_BITS-1:2];
    assign w_inflight_tag   = r_paddr[ADDR_W-1:OFFSET_BITS];
    assign w_snoop_tag      = snoop_addr[ADDR_W-1:OFFSET_BITS];
    assign w_misaligned     = (pte_addr[1:0] != 2'b00);
    assign w_fill           = (r_state == ST_FETCH) && pmem_resp;
    assign w_snoop_inflight = snoop_write && (r_state == ST_FETCH) &&
                              (w_snoop_tag == w_inflight_tag);
    // A line that was disturbed at any point while in flight must not be trusted later.
    assign w_fill_valid     = !(r_poison || flush_tlb || w_snoop_inflight);
    assign w_hit            = w_buf_hit && !flush_tlb && !w_buf_snoop;
    assign w_unused         = ^snoop_addr[OFFSET_BITS-1:0];

    pte_line_buffer #(
        .LINE_BITS   (LINE_BITS),
        .ADDR_W      (ADDR_W),
        .OFFSET_BITS (OFFSET_BITS)
    ) u_line_buffer (
        .clk         (clk),
        .rst         (rst),
        .lookup_tag  (w_req_tag),
        .word_sel    (w_sel),
        .fill_en     (w_fill),
        .fill_valid  (w_fill_valid),
        .fill_tag    (w_inflight_tag),
        .fill_data   (pmem_rdata),
        .flush       (flush_tlb),
        .snoop_write (snoop_write),
        .snoop_tag   (w_snoop_tag),
        .hit         (w_buf_hit),
        .snoop_match (w_buf_snoop),
        .word_out    (w_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (mem_read) begin
                    w_next = (w_misaligned || w_hit) ? ST_RESPOND : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (pmem_resp) begin
                    w_next = ST_RESPOND;
                end
            end
            ST_RESPOND: w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pte    <= '0;
            r_fault  <= 1'b0;
            r_poison <= 1'b0;
            r_paddr  <= '0;
            r_hits   <= '0;
            r_misses <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (mem_read) begin
                        if (w_misaligned) begin
                            r_pte   <= '0;
                            r_fault <= 1'b1;
                        end else if (w_hit) begin
                            r_pte   <= w_word;
                            r_fault <= 1'b0;
                            r_hits  <= (r_hits == C_SAT) ? r_hits : r_hits + 32'd1;
                        end else begin
                            r_paddr  <= {w_req_tag, {OFFSET_BITS{1'b0}}};
                            r_fault  <= 1'b0;
                            r_poison <= 1'b0;
                            r_misses <= (r_misses == C_SAT) ? r_misses : r_misses + 32'd1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (flush_tlb || w_snoop_inflight) begin
                        r_poison <= 1'b1;
                    end
                    if (pmem_resp) begin
                        r_pte <= w_word;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pte_in       = r_pte;
    assign mem_resp     = (r_state == ST_RESPOND);
    assign access_fault = (r_state == ST_RESPOND) && r_fault;
    assign pmem_read    = (r_state == ST_FETCH);
    assign pmem_address = r_paddr;
    assign hit_count    = r_hits;
    assign miss_count   = r_misses;

endmodule
`default_nettype wire

// File: tb/tb_pte_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pte_fetch_unit
//  Purpose  : Self-checking bench for pte_fetch_unit (vector table + scoreboard).
//  Revision : 1.0
// ============================================================================
module tb_pte_fetch_unit;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  pte_addr;
    logic         mem_read;
    logic         flush_tlb;
    logic [31:0]  snoop_addr;
    logic         snoop_write;
    logic [31:0]  pte_in;
    logic         mem_resp;
    logic         access_fault;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pte_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .pte_addr     (pte_addr),
        .mem_read     (mem_read),
        .flush_tlb    (flush_tlb),
        .snoop_addr   (snoop_addr),
        .snoop_write  (snoop_write),
        .pte_in       (pte_in),
        .mem_resp     (mem_resp),
        .access_fault (access_fault),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    typedef struct {
        logic [31:0] data;
        logic        fault;
    } exp_t;

    // pre: 0 none, 1 snoop cycle before request, 2 flush cycle before request.
    // flush_at/snoop_at: cycle index within the request (-1 = never, 0 = with mem_read).
    typedef struct {
        logic [31:0] addr;
        int          delay;
        int          pre;
        int          flush_at;
        int          snoop_at;
        logic [31:0] snoop_a;
        bit          exp_fetch;
        bit          exp_fault;
        int          exp_hits;
        int          exp_misses;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[15];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] base;
        logic [2:0]  k;
        base = {a[31:5], 5'b0};
        k    = a[4:2];
        if (base == 32'h8000_1000 && k == 3'd1) return 32'h2000_0C01;
        if (base == 32'h8000_1000 && k == 3'd7) return 32'hDEAD_BEEF;
        return (base ^ 32'h5A5A_0000) + {29'd0, k} * 32'h0101_0101 + 32'h11;
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        logic [255:0] l;
        logic [31:0]  base;
        base = {a[31:5], 5'b0};
        for (int k = 0; k < 8; k++) l[32*k +: 32] = mem_word(base + 32'(4 * k));
        return l;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        exp_t g;
        bit   got;
        bit   fetched;
        int   lat;
        int   exp_lat;
        if (v.pre == 1) begin
            snoop_addr  = v.snoop_a;
            snoop_write = 1'b1;
            @(negedge clk);
            snoop_write = 1'b0;
        end else if (v.pre == 2) begin
            flush_tlb = 1'b1;
            @(negedge clk);
            flush_tlb = 1'b0;
        end
        e.data  = v.exp_fault ? 32'h0 : mem_word(v.addr);
        e.fault = v.exp_fault;
        sb.push_back(e);
        pte_addr   = v.addr;
        mem_read   = 1'b1;
        pmem_rdata = mem_line(v.addr);
        if (v.snoop_at == 0) begin
            snoop_addr  = v.snoop_a;
            snoop_write = 1'b1;
        end
        if (v.flush_at == 0) flush_tlb = 1'b1;
        got     = 1'b0;
        fetched = 1'b0;
        lat     = 0;
        exp_lat = v.exp_fetch ? v.delay + 2 : 1;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            flush_tlb   = 1'b0;
            snoop_write = 1'b0;
            pmem_resp   = 1'b0;
            if (pmem_read) begin
                if (!fetched) check32($sformatf("v%0d pmem_address", idx), pmem_address,
                                      {v.addr[31:5], 5'b0});
                fetched = 1'b1;
                if (c == v.delay + 1) pmem_resp = 1'b1;
            end
            if (c == v.flush_at) flush_tlb = 1'b1;
            if (c == v.snoop_at) begin
                snoop_addr  = v.snoop_a;
                snoop_write = 1'b1;
            end
            if (mem_resp) begin
                got      = 1'b1;
                lat      = c;
                mem_read = 1'b0;
                g        = sb.pop_front();
                check32($sformatf("v%0d pte_in", idx), pte_in, g.data);
                check32($sformatf("v%0d access_fault", idx), {31'd0, access_fault}, {31'd0, g.fault});
            end
        end
        flush_tlb   = 1'b0;
        snoop_write = 1'b0;
        pmem_resp   = 1'b0;
        mem_read    = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL v%0d timeout: got no mem_resp expected one within 40 cycles", idx);
            void'(sb.pop_front());
        end else begin
            check32($sformatf("v%0d latency", idx), 32'(lat), 32'(exp_lat));
        end
        check32($sformatf("v%0d fetch_issued", idx), {31'd0, fetched}, {31'd0, v.exp_fetch});
        @(negedge clk);
        check32($sformatf("v%0d mem_resp_pulse", idx), {31'd0, mem_resp}, 32'd0);
        check32($sformatf("v%0d hit_count", idx), hit_count, 32'(v.exp_hits));
        check32($sformatf("v%0d miss_count", idx), miss_count, 32'(v.exp_misses));
    endtask

    initial begin
        bit seen;
        vecs[0]  = '{32'h8000_1004, 3, 0, -1, -1, 32'h0,          1'b1, 1'b0, 0, 1};
        vecs[1]  = '{32'h8000_101C, 0, 0, -1, -1, 32'h0,          1'b0, 1'b0, 1, 1};
        vecs[2]  = '{32'h8000_1004, 1, 1, -1, -1, 32'h8000_1010, 1'b1, 1'b0, 1, 2};
        vecs[3]  = '{32'h8000_1008, 2, 2, -1,  2, 32'h8000_1010, 1'b1, 1'b0, 1, 3};
        vecs[4]  = '{32'h8000_100C, 1, 0, -1, -1, 32'h0,          1'b1, 1'b0, 1, 4};
        vecs[5]  = '{32'h8000_1010, 0, 0, -1, -1, 32'h0,          1'b0, 1'b0, 2, 4};
        vecs[6]  = '{32'h8000_2000, 2, 0,  3, -1, 32'h0,          1'b1, 1'b0, 2, 5};
        vecs[7]  = '{32'h8000_2004, 0, 0, -1, -1, 32'h0,          1'b1, 1'b0, 2, 6};
        vecs[8]  = '{32'h8000_1002, 0, 0, -1, -1, 32'h0,          1'b0, 1'b1, 2, 6};
        vecs[9]  = '{32'h8000_2008, 0, 0, -1, -1, 32'h0,          1'b0, 1'b0, 3, 6};
        vecs[10] = '{32'h8000_2008, 1, 2, -1, -1, 32'h0,          1'b1, 1'b0, 3, 7};
        vecs[11] = '{32'h8000_3000, 1, 0, -1,  1, 32'h8000_4000, 1'b1, 1'b0, 3, 8};
        vecs[12] = '{32'h8000_3004, 0, 0, -1, -1, 32'h0,          1'b0, 1'b0, 4, 8};
        vecs[13] = '{32'h8000_3008, 0, 0, -1,  0, 32'h8000_3000, 1'b1, 1'b0, 4, 9};
        vecs[14] = '{32'h8000_301C, 0, 0, -1, -1, 32'h0,          1'b0, 1'b0, 5, 9};

        rst         = 1'b1;
        pte_addr    = '0;
        mem_read    = 1'b0;
        flush_tlb   = 1'b0;
        snoop_addr  = '0;
        snoop_write = 1'b0;
        pmem_rdata  = '0;
        pmem_resp   = 1'b0;
        repeat (2) @(negedge clk);
        check32("reset pte_in", pte_in, 32'h0);
        check32("reset mem_resp", {31'd0, mem_resp}, 32'd0);
        check32("reset access_fault", {31'd0, access_fault}, 32'd0);
        check32("reset pmem_read", {31'd0, pmem_read}, 32'd0);
        check32("reset pmem_address", pmem_address, 32'h0);
        check32("reset hit_count", hit_count, 32'h0);
        check32("reset miss_count", miss_count, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

        // Reset while a line fetch is outstanding.
        pte_addr   = 32'h8000_5000;
        mem_read   = 1'b1;
        pmem_rdata = mem_line(32'h8000_5000);
        seen       = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge clk);
            seen = pmem_read;
        end
        check32("midfetch pmem_read_seen", {31'd0, seen}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check32("midfetch pmem_read_drop", {31'd0, pmem_read}, 32'd0);
        check32("midfetch mem_resp", {31'd0, mem_resp}, 32'd0);
        check32("midfetch miss_count", miss_count, 32'h0);
        check32("midfetch hit_count", hit_count, 32'h0);
        mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_vec('{32'h8000_5004, 1, 0, -1, -1, 32'h0, 1'b1, 1'b0, 0, 1}, 15);
        run_vec('{32'h8000_5008, 0, 0, -1, -1, 32'h0, 1'b0, 1'b0, 1, 1}, 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
